// File: rtl/alu_dec_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_dec_pipe: ALUOp/Funct decoder registered into ID/EX, with handshake, |
// | stall/flush, illegal-funct flag and mult/div busy interlock.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_dec_pipe #(
  parameter int CTRL_W   = 4,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic              Stall,
  input  logic              Flush,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              OutValid,
  output logic              Illegal,
  output logic              MDStart,
  output logic              MDBusy
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] c_and  = 4'h0;
  localparam logic [3:0] c_or   = 4'h1;
  localparam logic [3:0] c_add  = 4'h2;
  localparam logic [3:0] c_xor  = 4'h3;
  localparam logic [3:0] c_nor  = 4'h4;
  localparam logic [3:0] c_lui  = 4'h5;
  localparam logic [3:0] c_sub  = 4'h6;
  localparam logic [3:0] c_slt  = 4'h7;
  localparam logic [3:0] c_sltu = 4'h8;
  localparam logic [3:0] c_sll  = 4'h9;
  localparam logic [3:0] c_srl  = 4'ha;
  localparam logic [3:0] c_sra  = 4'hb;
  localparam logic [3:0] c_mult = 4'hc;
  localparam logic [3:0] c_div  = 4'hd;
  localparam logic [3:0] c_nop  = 4'hf;

  logic [3:0]       w_code;
  logic             w_illegal;
  logic             w_is_md;
  logic             w_accept;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_ctrl;
  logic             r_valid;
  logic             r_illegal;
  logic             r_mdstart;

  always_comb begin
    w_code    = c_nop;
    w_illegal = 1'b0;
    case (ALUOp)
      3'b000: w_code = c_add;
      3'b001: w_code = c_sub;
      3'b011: w_code = c_and;
      3'b100: w_code = c_or;
      3'b101: w_code = c_slt;
      3'b110: w_code = c_xor;
      3'b111: w_code = c_lui;
      3'b010: begin
        case (Funct)
          6'b100000, 6'b100001: w_code = c_add;
          6'b100010, 6'b100011: w_code = c_sub;
          6'b100100:            w_code = c_and;
          6'b100101:            w_code = c_or;
          6'b100110:            w_code = c_xor;
          6'b100111:            w_code = c_nor;
          6'b101010:            w_code = c_slt;
          6'b101011:            w_code = c_sltu;
          6'b000000:            w_code = c_sll;
          6'b000010:            w_code = c_srl;
          6'b000011:            w_code = c_sra;
          6'b011000, 6'b011001: w_code = c_mult;
          6'b011010, 6'b011011: w_code = c_div;
          default:              w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign w_is_md  = (w_code == c_mult) || (w_code == c_div);
  assign MDBusy   = (r_cnt != '0);
  assign InReady  = !Stall && !(w_is_md && MDBusy);
  assign w_accept = InValid && InReady;

  // The counter runs through stalls and flushes; only a surviving MD accept reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && w_is_md && !Flush) begin
      r_cnt <= (w_code == c_div) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= c_nop;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_mdstart <= 1'b0;
    end else if (Flush) begin
      r_ctrl    <= c_nop;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_mdstart <= 1'b0;
    end else if (Stall) begin
      r_mdstart <= 1'b0;
    end else if (w_accept) begin
      r_ctrl    <= w_code;
      r_valid   <= 1'b1;
      r_illegal <= w_illegal;
      r_mdstart <= w_is_md;
    end else begin
      r_ctrl    <= c_nop;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_mdstart <= 1'b0;
    end
  end

  assign ALUControl = CTRL_W'(r_ctrl);
  assign OutValid   = r_valid;
  assign Illegal    = r_illegal;
  assign MDStart    = r_mdstart;

endmodule
`default_nettype wire
